// File: rtl/elevator_pkg.sv
// Shared codes for the elevator call scheduler: motor, floor and movement encodings,
// scheduler state encoding and a floor-to-one-hot helper.
package elevator_pkg;

    typedef enum logic [1:0] {
        MC_STOP = 2'b00,
        MC_DOWN = 2'b01,
        MC_UP   = 2'b10
    } motor_e;

    typedef enum logic [1:0] {
        FL0 = 2'b00,
        FL1 = 2'b01,
        FL2 = 2'b10
    } floor_e;

    typedef enum logic [1:0] {
        MV_STAY = 2'b00,
        MV_DOWN = 2'b01,
        MV_UP   = 2'b10
    } move_e;

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        ISSUE,
        SETTLE,
        DOOR
    } sched_state_e;

    // Floor code 11 is invalid and maps to no floor at all.
    function automatic logic [2:0] floor_onehot(input logic [1:0] fl);
        case (fl)
            FL0:     return 3'b001;
            FL1:     return 3'b010;
            FL2:     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Signal bundle between the call scheduler (master) and the floor FSM / call sources (slave).
interface elevator_call_scheduler_if;
    import elevator_pkg::*;

    logic [2:0] call_req;
    logic [1:0] floor;
    logic [1:0] movement;
    logic [1:0] motor_control;
    logic       update;
    logic [2:0] pending;
    logic       door_open;
    logic       busy;

    modport master (
        input  call_req, floor, movement,
        output motor_control, update, pending, door_open, busy
    );

    modport slave (
        output call_req, floor, movement,
        input  motor_control, update, pending, door_open, busy
    );

endinterface

// File: rtl/elevator_call_register.sv
// Pending-call latch for floors 0-2 with per-cycle set/clear, plus
// "request above" / "request below" flags relative to the current floor.
module elevator_call_register
    import elevator_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] set_i,
    input  logic [2:0] clr_i,
    input  logic [1:0] floor_i,
    output logic [2:0] pending_o,
    output logic [2:0] pending_next_o,
    output logic       above_o,
    output logic       below_o
);

    logic [2:0] pending_q;
    logic [2:0] pending_d;

    // Clear wins over set so a call for the floor being serviced is absorbed.
    always_comb begin
        pending_d = (pending_q | set_i) & ~clr_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 3'b000;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        above_o = 1'b0;
        below_o = 1'b0;
        case (floor_i)
            FL0: above_o = |pending_q[2:1];
            FL1: begin
                above_o = pending_q[2];
                below_o = pending_q[0];
            end
            FL2: below_o = |pending_q[1:0];
            default: ;
        endcase
    end

    assign pending_o      = pending_q;
    assign pending_next_o = pending_d;

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN-policy call scheduler feeding the elevator floor FSM: latches calls, picks the next
// motor command, strobes update once per command and paces travel/door dwell with one timer.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int STEP_CYCLES = 8,
    parameter int DOOR_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    elevator_call_scheduler_if.master   bus
);

    localparam int TMAX = (STEP_CYCLES > DOOR_CYCLES) ? STEP_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES);
    localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    sched_state_e   state_q, state_d;
    logic           dir_up_q, dir_up_d;
    logic [1:0]     cmd_q, cmd_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [2:0]     clr;
    logic [2:0]     pend_q;
    logic [2:0]     pend_nxt;
    logic           above;
    logic           below;
    logic           floor_pending;
    logic           unused_movement;

    // Movement from the floor FSM is informational; decisions use floor only.
    assign unused_movement = ^bus.movement;

    assign clr           = (state_q == DOOR) ? floor_onehot(bus.floor) : 3'b000;
    assign floor_pending = |(pend_q & floor_onehot(bus.floor));

    elevator_call_register u_calls (
        .clk            (clk),
        .reset_n        (reset_n),
        .set_i          (bus.call_req),
        .clr_i          (clr),
        .floor_i        (bus.floor),
        .pending_o      (pend_q),
        .pending_next_o (pend_nxt),
        .above_o        (above),
        .below_o        (below)
    );

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cmd_d    = cmd_q;
        timer_d  = (timer_q != '0) ? timer_q - T_ONE : '0;

        case (state_q)
            // Look at next-cycle pending so a call sampled now reaches DECIDE one cycle later.
            IDLE: begin
                if (pend_nxt != 3'b000) state_d = DECIDE;
            end
            DECIDE: begin
                state_d = ISSUE;
                cmd_d   = MC_STOP;
                if (bus.floor == 2'b11) begin
                    state_d = IDLE;
                end else if (floor_pending) begin
                    cmd_d = MC_STOP;
                end else if (dir_up_q && above) begin
                    cmd_d = MC_UP;
                end else if (below) begin
                    cmd_d    = MC_DOWN;
                    dir_up_d = 1'b0;
                end else if (above) begin
                    cmd_d    = MC_UP;
                    dir_up_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (cmd_q == MC_STOP) begin
                    state_d = DOOR;
                    timer_d = DOOR_LOAD;
                end else begin
                    state_d = SETTLE;
                    timer_d = STEP_LOAD;
                end
            end
            SETTLE, DOOR: begin
                if (timer_q <= T_ONE) state_d = DECIDE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_up_q <= 1'b1;
            cmd_q    <= MC_STOP;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
            cmd_q    <= cmd_d;
            timer_q  <= timer_d;
        end
    end

    assign bus.update        = (state_q == ISSUE);
    assign bus.motor_control = ((state_q == ISSUE) || (state_q == SETTLE)) ? cmd_q : MC_STOP;
    assign bus.door_open     = (state_q == DOOR);
    assign bus.busy          = (state_q != IDLE);
    assign bus.pending       = pend_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler with a simple floor-FSM load model.
module tb_elevator_call_scheduler;
    import elevator_pkg::*;

    typedef struct packed {
        logic [1:0] cmd;
        logic [1:0] flr;
    } exp_t;

    logic clk;
    logic reset_n;
    logic upd_seen;

    int   errors;
    int   checks;
    exp_t exp_q[$];
    int   m_floor;
    bit   m_up;

    elevator_call_scheduler_if bus();

    elevator_call_scheduler #(.STEP_CYCLES(8), .DOOR_CYCLES(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floor FSM load: edge-detects update and moves one floor per strobe.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.floor    <= 2'b00;
            bus.movement <= MV_STAY;
            upd_seen     <= 1'b0;
        end else begin
            upd_seen <= bus.update;
            if (bus.update && !upd_seen) begin
                if (bus.motor_control == 2'b10 && bus.floor < 2'b10) begin
                    bus.floor    <= bus.floor + 2'b01;
                    bus.movement <= MV_UP;
                end else if (bus.motor_control == 2'b01 && bus.floor > 2'b00) begin
                    bus.floor    <= bus.floor - 2'b01;
                    bus.movement <= MV_DOWN;
                end else begin
                    bus.movement <= MV_STAY;
                end
            end
        end
    end

    function automatic void chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endfunction

    // SCAN reference: walks the request set floor by floor and records every command strobe.
    task automatic model_episode(input logic [2:0] p, input logic [2:0] q);
        int         f;
        bit         up;
        bit         svc;
        bit         above;
        bit         below;
        logic [2:0] pend;
        exp_t       e;
        f    = m_floor;
        up   = m_up;
        pend = p;
        for (int step = 0; step < 12; step++) begin
            if (pend == 3'b000) break;
            above = 0;
            below = 0;
            for (int k = 0; k < 3; k++) begin
                if (pend[k] && k > f) above = 1;
                if (pend[k] && k < f) below = 1;
            end
            svc   = 0;
            e.flr = 2'(f);
            if (pend[f]) begin
                e.cmd   = 2'b00;
                pend[f] = 1'b0;
                svc     = 1;
            end else if (up && above) begin
                e.cmd = 2'b10;
                f++;
            end else if (below) begin
                e.cmd = 2'b01;
                up    = 0;
                f--;
            end else begin
                e.cmd = 2'b10;
                up    = 1;
                f++;
            end
            exp_q.push_back(e);
            if (step == 0) pend = pend | (svc ? (q & ~(3'b001 << f)) : q);
        end
        m_floor = f;
        m_up    = up;
    endtask

    // Monitor: compares each strobe against the scoreboard and measures door dwell.
    initial begin
        bit   prev_upd;
        int   door_run;
        exp_t e;
        prev_upd = 0;
        door_run = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_upd = 0;
                door_run = 0;
            end else begin
                if (bus.update) begin
                    chk("update_gap", int'(prev_upd), 0);
                    chk("up_at_top", int'(bus.motor_control == 2'b10 && bus.floor == 2'b10), 0);
                    chk("down_at_bottom", int'(bus.motor_control == 2'b01 && bus.floor == 2'b00), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got cmd %0d at floor %0d, required no strobe",
                                 bus.motor_control, bus.floor);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_cmd", int'(bus.motor_control), int'(e.cmd));
                        chk("strobe_floor", int'(bus.floor), int'(e.flr));
                    end
                end
                if (bus.door_open) begin
                    door_run++;
                end else if (door_run != 0) begin
                    chk("door_len", door_run, 16);
                    door_run = 0;
                end
                prev_upd = bus.update;
            end
        end
    end

    task automatic pulse(input logic [2:0] v);
        bus.call_req = v;
        @(negedge clk);
        bus.call_req = 3'b000;
    endtask

    task automatic wait_update();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.update) return;
        end
        chk("update_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic run_episode(input logic [2:0] p, input logic [2:0] q);
        model_episode(p, q);
        pulse(p);
        wait_update();
        repeat (3) @(negedge clk);
        pulse(q);
        wait_idle();
        chk("end_pending", int'(bus.pending), 0);
        chk("end_expect_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic door_hold_test();
        model_episode(3'b010, 3'b000);
        bus.call_req = 3'b010;
        for (int i = 0; i < 40 && !bus.door_open; i++) @(negedge clk);
        chk("hold_door_open", int'(bus.door_open), 1);
        repeat (4) @(negedge clk);
        chk("hold_pending_mid", int'(bus.pending[1]), 0);
        for (int i = 0; i < 40 && bus.door_open; i++) @(negedge clk);
        bus.call_req = 3'b000;
        wait_idle();
        chk("hold_end_pending", int'(bus.pending), 0);
        chk("hold_expect_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] p;
        logic [2:0] q;
        errors       = 0;
        checks       = 0;
        m_floor      = 0;
        m_up         = 1;
        reset_n      = 1'b0;
        bus.call_req = 3'b000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_update", int'(bus.update), 0);
        chk("rst_motor", int'(bus.motor_control), 0);
        chk("rst_door", int'(bus.door_open), 0);

        // Reset asserted in the middle of travel.
        model_episode(3'b100, 3'b000);
        pulse(3'b100);
        wait_update();
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_update", int'(bus.update), 0);
        chk("arst_motor", int'(bus.motor_control), 0);
        chk("arst_pending", int'(bus.pending), 0);
        chk("arst_door", int'(bus.door_open), 0);
        chk("arst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        m_floor = 0;
        m_up    = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(bus.busy), 0);
        chk("post_rst_pending", int'(bus.pending), 0);

        run_episode(3'b001, 3'b000);
        run_episode(3'b100, 3'b001);
        run_episode(3'b100, 3'b000);
        run_episode(3'b010, 3'b000);
        door_hold_test();

        for (int n = 0; n < 24; n++) begin
            p = 3'($urandom_range(1, 7));
            q = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
            run_episode(p, q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
